dmem_responder: RTL and testbench

Responder (slave) end of the pipeline's data-memory port. It accepts load/store requests carrying a byte address, write data and a byte-enable mask, and holds word-organised storage with per-byte write lanes. It inserts a configurable number of wait states and returns read data and an error flag through a valid/ready handshake. It sits between the MEM stage and the hazard unit; `req_ready` low is the stall source for the pipeline.

---
 rtl/dmem_pkg.sv | 32 +++
 rtl/dmem_lane_steer.sv | 22 ++
 rtl/dmem_responder.sv | 151 +++++++++++++++
 tb/tb_dmem_responder.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared types, byte-enable encodings and mask legality check for dmem_responder
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

    localparam logic [3:0] BE_B0  = 4'b0001;
    localparam logic [3:0] BE_B1  = 4'b0010;
    localparam logic [3:0] BE_B2  = 4'b0100;
    localparam logic [3:0] BE_B3  = 4'b1000;
    localparam logic [3:0] BE_HLO = 4'b0011;
    localparam logic [3:0] BE_HHI = 4'b1100;
    localparam logic [3:0] BE_W   = 4'b1111;

    // True when the mask is a byte/half/word pattern that matches the low address bits.
    function automatic logic be_legal(input logic [3:0] be, input logic [1:0] addr_lo);
        logic ok;
        ok = 1'b0;
        case (be)
            BE_B0, BE_B1, BE_B2, BE_B3: ok = (be == (4'b0001 << addr_lo));
            BE_HLO:                     ok = (addr_lo == 2'b00);
            BE_HHI:                     ok = (addr_lo == 2'b10);
            BE_W:                       ok = (addr_lo == 2'b00);
            default:                    ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/dmem_lane_steer.sv
// rtl/dmem_lane_steer.sv - replicates store data onto the byte lanes selected by the mask
module dmem_lane_steer
    import dmem_pkg::*;
(
    input  logic [3:0]  be,
    input  logic [31:0] wdata,
    output logic [31:0] wword,
    output logic [3:0]  strb
);

    // Replication lets the strobes alone pick the destination lane.
    always_comb begin
        wword = {4{wdata[7:0]}};
        case (be)
            BE_W:           wword = wdata;
            BE_HLO, BE_HHI: wword = {2{wdata[15:0]}};
            default:        wword = {4{wdata[7:0]}};
        endcase
        strb = be;
    end

endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - data-memory responder with wait states, byte lanes and access checking
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int ADDR_WIDTH  = 10,
    parameter int WAIT_STATES = 1
) (
    input  logic        clk,
    input  logic        clr,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        busy
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [2:0] LAST = (WAIT_STATES > 0) ? 3'(WAIT_STATES - 1) : 3'd0;

    logic [31:0] mem [DEPTH];

    state_e      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  be_q, be_d;
    logic        err_q, err_d;
    logic [31:0] rdata_q, rdata_d;
    logic        rerr_q, rerr_d;

    logic        req_err;
    logic        enter_resp;
    logic        cur_we, cur_err;
    logic [31:0] cur_addr, cur_wdata;
    logic [3:0]  cur_be;
    logic [ADDR_WIDTH-1:0] cur_idx;
    logic [31:0] st_word;
    logic [3:0]  st_strb;
    logic        mem_we;

    assign req_err = !be_legal(req_be, req_addr[1:0]) ||
                     ((req_addr >> (ADDR_WIDTH + 2)) != 32'd0);

    // With zero wait states the commit happens on the accept edge, so use the live request.
    always_comb begin
        cur_we    = (state_q == IDLE) ? req_we    : we_q;
        cur_err   = (state_q == IDLE) ? req_err   : err_q;
        cur_addr  = (state_q == IDLE) ? req_addr  : addr_q;
        cur_wdata = (state_q == IDLE) ? req_wdata : wdata_q;
        cur_be    = (state_q == IDLE) ? req_be    : be_q;
        cur_idx   = cur_addr[ADDR_WIDTH+1:2];
    end

    dmem_lane_steer u_steer (
        .be    (cur_be),
        .wdata (cur_wdata),
        .wword (st_word),
        .strb  (st_strb)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        be_d       = be_q;
        err_d      = err_q;
        enter_resp = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    we_d    = req_we;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    be_d    = req_be;
                    err_d   = req_err;
                    cnt_d   = 3'd0;
                    if (WAIT_STATES == 0) begin
                        state_d    = RESP;
                        enter_resp = 1'b1;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == LAST) begin
                    state_d    = RESP;
                    enter_resp = 1'b1;
                end else begin
                    cnt_d = cnt_q + 3'd1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        rdata_d = (enter_resp && !cur_we && !cur_err) ? mem[cur_idx] : 32'd0;
        rerr_d  = enter_resp ? cur_err : 1'b0;
    end

    // Gating on clr keeps a request presented during reset from touching storage.
    assign mem_we = enter_resp && cur_we && !cur_err && clr;

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q <= IDLE;
            cnt_q   <= 3'd0;
            we_q    <= 1'b0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            be_q    <= 4'd0;
            err_q   <= 1'b0;
            rdata_q <= 32'd0;
            rerr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
            rerr_q  <= rerr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (st_strb[i]) begin
                    mem[cur_idx][8*i +: 8] <= st_word[8*i +: 8];
                end
            end
        end
    end

    assign req_ready = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign rsp_valid = (state_q == RESP);
    assign rsp_rdata = rdata_q;
    assign rsp_err   = rerr_q;

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - directed scoreboard bench for dmem_responder with two wait states
module tb_dmem_responder;

    logic        clk;
    logic        clr;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_be;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        busy;

    int tests = 0;
    int fails = 0;
    logic [32:0] sb [$];

    dmem_responder #(.ADDR_WIDTH(10), .WAIT_STATES(2)) dut (
        .clk       (clk),
        .clr       (clr),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_be    (req_be),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        while (req_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) chk("ready_timeout", {31'd0, req_ready}, 32'd1);
    endtask

    // One transaction: drive, accept, then check stall window, response cycle and return to idle.
    task automatic xact(input string tag, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] be,
                        input logic exp_err, input logic [31:0] exp_rdata);
        logic [32:0] e;
        @(negedge clk);
        wait_ready();
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        req_be    = be;
        sb.push_back({exp_err, exp_rdata});
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            if (k > 1) @(negedge clk);
            chk({tag, "_ready_low"}, {31'd0, req_ready}, 32'd0);
            chk({tag, "_valid_cyc"}, {31'd0, rsp_valid}, {31'd0, (k == 3)});
            if (k == 3) begin
                e = sb.pop_front();
                chk({tag, "_rdata"}, rsp_rdata, e[31:0]);
                chk({tag, "_err"}, {31'd0, rsp_err}, {31'd0, e[32]});
            end
        end
        @(negedge clk);
        chk({tag, "_ready_back"}, {31'd0, req_ready}, 32'd1);
        chk({tag, "_valid_drop"}, {31'd0, rsp_valid}, 32'd0);
    endtask

    initial begin
        clr       = 1'b1;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = 32'd0;
        req_wdata = 32'd0;
        req_be    = 4'd0;
        #2 clr = 1'b0;
        #1;
        chk("rst_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_rdata", rsp_rdata, 32'd0);
        chk("rst_err", {31'd0, rsp_err}, 32'd0);
        repeat (2) @(negedge clk);
        clr = 1'b1;

        xact("sw10", 1'b1, 32'h10, 32'hDEADBEEF, 4'b1111, 1'b0, 32'd0);
        xact("lw10", 1'b0, 32'h10, 32'd0, 4'b1111, 1'b0, 32'hDEADBEEF);

        xact("sw4", 1'b1, 32'h4, 32'h11223344, 4'b1111, 1'b0, 32'd0);
        xact("sb5", 1'b1, 32'h5, 32'h000000AB, 4'b0010, 1'b0, 32'd0);
        xact("lw4a", 1'b0, 32'h4, 32'd0, 4'b1111, 1'b0, 32'h1122AB44);
        xact("sh6", 1'b1, 32'h6, 32'h0000CAFE, 4'b1100, 1'b0, 32'd0);
        xact("lw4b", 1'b0, 32'h4, 32'd0, 4'b1111, 1'b0, 32'hCAFEAB44);

        xact("sw0", 1'b1, 32'h0, 32'hA5A5A5A5, 4'b1111, 1'b0, 32'd0);
        xact("sw_mis", 1'b1, 32'h2, 32'h01020304, 4'b1111, 1'b1, 32'd0);
        xact("sw_be5", 1'b1, 32'h0, 32'h01020304, 4'b0101, 1'b1, 32'd0);
        xact("sw_be0", 1'b1, 32'h0, 32'h01020304, 4'b0000, 1'b1, 32'd0);
        xact("sb_mis", 1'b1, 32'h1, 32'h000000FF, 4'b0001, 1'b1, 32'd0);
        xact("lw0", 1'b0, 32'h0, 32'd0, 4'b1111, 1'b0, 32'hA5A5A5A5);
        xact("lw_mis", 1'b0, 32'h1, 32'd0, 4'b1100, 1'b1, 32'd0);

        xact("sw_top", 1'b1, 32'hFFC, 32'hCAFEF00D, 4'b1111, 1'b0, 32'd0);
        xact("lw_oor", 1'b0, 32'h1000, 32'd0, 4'b1111, 1'b1, 32'd0);
        xact("lw_top", 1'b0, 32'hFFC, 32'd0, 4'b1111, 1'b0, 32'hCAFEF00D);

        xact("sw20z", 1'b1, 32'h20, 32'h00000000, 4'b1111, 1'b0, 32'd0);
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = 32'h20;
        req_wdata = 32'h12345678;
        req_be    = 4'b1111;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        chk("abort_busy_pre", {31'd0, busy}, 32'd1);
        clr = 1'b0;
        #1;
        chk("abort_ready", {31'd0, req_ready}, 32'd1);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_valid", {31'd0, rsp_valid}, 32'd0);
        @(negedge clk);
        clr = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("abort_no_rsp", {31'd0, rsp_valid}, 32'd0);
        end
        xact("lw20", 1'b0, 32'h20, 32'd0, 4'b1111, 1'b0, 32'h00000000);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
